// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 VGA timing constants shared by the timing generator
package vga_pkg;

    localparam int CNT_W     = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int FC_W      = 8;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - video timing bundle produced by vga_timing_gen
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] DrawX;
    logic [CNT_W-1:0] DrawY;
    logic             hs;
    logic             vs;
    logic             active_nblank;
    logic             frame_start;
    logic [FC_W-1:0]  frame_count;
    logic             blink;

    modport master (
        output DrawX, DrawY, hs, vs, active_nblank, frame_start, frame_count, blink
    );

    modport slave (
        input  DrawX, DrawY, hs, vs, active_nblank, frame_start, frame_count, blink
    );

endinterface

// File: rtl/vga_timing_gen_sync_counter.sv
// rtl/vga_timing_gen_sync_counter.sv - modulo-N counter with enable and wrap pulse
module sync_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign count_o = count_q;
    assign wrap_o  = en_i && (count_q == LAST);

    // Next count: hold when disabled, return to zero after the last value.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; optional blink via VGA_TIMING_BLINK_EN
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS_P   = H_VISIBLE,
    parameter int H_FP_P    = H_FP,
    parameter int H_SYNC_P  = H_SYNC,
    parameter int H_TOTAL_P = H_TOTAL,
    parameter int V_VIS_P   = V_VISIBLE,
    parameter int V_FP_P    = V_FP,
    parameter int V_SYNC_P  = V_SYNC,
    parameter int V_TOTAL_P = V_TOTAL
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             hs,
    output logic             vs,
    output logic             active_nblank,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count,
    output logic             blink
);

    // Sync pulse occupies [START, END) on each axis, right after the front porch.
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS_P + H_FP_P);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS_P + H_FP_P + H_SYNC_P);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS_P + V_FP_P);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS_P + V_FP_P + V_SYNC_P);
    localparam logic [CNT_W-1:0] H_VIS_L  = CNT_W'(H_VIS_P);
    localparam logic [CNT_W-1:0] V_VIS_L  = CNT_W'(V_VIS_P);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             frame_end;
    logic [FC_W-1:0]  frame_count_q;

    sync_counter #(
        .MODULUS (H_TOTAL_P),
        .WIDTH   (CNT_W)
    ) u_h_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .count_o (h_cnt),
        .wrap_o  (h_wrap)
    );

    // The vertical wrap only fires on the horizontal wrap, so it marks the last pixel of a frame.
    sync_counter #(
        .MODULUS (V_TOTAL_P),
        .WIDTH   (CNT_W)
    ) u_v_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (h_wrap),
        .count_o (v_cnt),
        .wrap_o  (frame_end)
    );

    assign DrawX       = h_cnt;
    assign DrawY       = v_cnt;
    assign frame_count = frame_count_q;

    // Decode sync, blanking and frame start from the current counters; all idle in reset.
    always_comb begin
        hs            = 1'b1;
        vs            = 1'b1;
        active_nblank = 1'b0;
        frame_start   = 1'b0;
        if (!reset) begin
            hs            = !((h_cnt >= HS_START) && (h_cnt < HS_END));
            vs            = !((v_cnt >= VS_START) && (v_cnt < VS_END));
            active_nblank = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);
            frame_start   = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Completed-frame counter; a reset mid-frame clears it so the aborted frame never counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
        end else if (frame_end) begin
            frame_count_q <= frame_count_q + 1'b1;
        end
    end

`ifdef VGA_TIMING_BLINK_EN
    logic blink_q;

    // Toggle every 32 completed frames, i.e. when the low five count bits roll over.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= 1'b0;
        end else if (frame_end && (frame_count_q[4:0] == 5'd31)) begin
            blink_q <= !blink_q;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule
